// File: rtl/register_file.sv
// Two combinational read ports, one rising-edge write port; register 0 reads as zero.
// Optional same-cycle write-to-read forwarding under `define WRITE_BYPASS_EN.
module register_file #(
    parameter int ADDRSIZE = 5,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                regWrite,
    input  logic [ADDRSIZE-1:0] readReg1,
    input  logic [ADDRSIZE-1:0] readReg2,
    input  logic [ADDRSIZE-1:0] writeReg,
    input  logic [WORDSIZE-1:0] writeData,
    output logic [WORDSIZE-1:0] readData1,
    output logic [WORDSIZE-1:0] readData2
);
    localparam int DEPTH = 1 << ADDRSIZE;

    logic [WORDSIZE-1:0] regs_q [DEPTH];
    logic                wr_en;

    assign wr_en = regWrite && (writeReg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[writeReg] <= writeData;
        end
    end

    // Entry 0 is never written, but the read mux still forces zero so x0 is
    // correct even if storage were ever disturbed.
    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (!reset) begin
            if (readReg1 != '0) begin
                readData1 = regs_q[readReg1];
            end
            if (readReg2 != '0) begin
                readData2 = regs_q[readReg2];
            end
`ifdef WRITE_BYPASS_EN
            if (wr_en && (readReg1 == writeReg)) begin
                readData1 = writeData;
            end
            if (wr_en && (readReg2 == writeReg)) begin
                readData2 = writeData;
            end
`endif
        end
    end
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    logic        clk;
    logic        reset;
    logic        regWrite;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int checks;
    int errors;

    register_file #(.ADDRSIZE(5), .WORDSIZE(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // each vector: write on one edge, then read back after it with regWrite low
        vec[0] = '{1'b1, 5'd1,  32'h12345678, 5'd1,  5'd0,  32'h12345678, 32'h00000000};
        vec[1] = '{1'b1, 5'd2,  32'h9ABCDEF1, 5'd1,  5'd2,  32'h12345678, 32'h9ABCDEF1};
        vec[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vec[3] = '{1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd3,  32'h00000000, 32'h00000000};
        vec[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vec[5] = '{1'b1, 5'd1,  32'hCAFEF00D, 5'd1,  5'd2,  32'hCAFEF00D, 32'h9ABCDEF1};
        vec[6] = '{1'b0, 5'd1,  32'h00000000, 5'd1,  5'd31, 32'hCAFEF00D, 32'hA5A5A5A5};
        vec[7] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd0,  32'h11111111, 32'h00000000};
        vec[8] = '{1'b1, 5'd16, 32'h5A5A5A5A, 5'd16, 5'd15, 32'h5A5A5A5A, 32'h00000000};

        reset     = 1'b0;
        regWrite  = 1'b0;
        readReg1  = 5'd1;
        readReg2  = 5'd31;
        writeReg  = 5'd0;
        writeData = 32'h0;
        #1 reset = 1'b1;
        #1;
        chk("reset_rd1", readData1, 32'h0);
        chk("reset_rd2", readData2, 32'h0);

        // write attempted while reset is held must be ignored
        regWrite  = 1'b1;
        writeReg  = 5'd4;
        writeData = 32'h44444444;
        @(posedge clk);
        #1 reset = 1'b0;
        regWrite = 1'b0;
        readReg1 = 5'd4;
        #1;
        chk("write_during_reset", readData1, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            regWrite  = vec[i].we;
            writeReg  = vec[i].wreg;
            writeData = vec[i].wdata;
            @(posedge clk);
            #1;
            regWrite = 1'b0;
            readReg1 = vec[i].r1;
            readReg2 = vec[i].r2;
            #1;
            chk($sformatf("vec%0d_rd1", i), readData1, vec[i].exp1);
            chk($sformatf("vec%0d_rd2", i), readData2, vec[i].exp2);
        end

        // same-cycle read and write of reg 5 (holds 11111111)
        @(posedge clk);
        #1;
        regWrite  = 1'b1;
        writeReg  = 5'd5;
        writeData = 32'h22222222;
        readReg1  = 5'd5;
        readReg2  = 5'd0;
        #1;
`ifdef WRITE_BYPASS_EN
        chk("same_cycle_before_edge", readData1, 32'h22222222);
`else
        chk("same_cycle_before_edge", readData1, 32'h11111111);
`endif
        chk("same_cycle_x0", readData2, 32'h0);
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        #1;
        chk("same_cycle_after_edge", readData1, 32'h22222222);

        // reset mid-cycle with a pending write: outputs drop at once, storage cleared
        @(posedge clk);
        #1;
        regWrite  = 1'b1;
        writeReg  = 5'd6;
        writeData = 32'h66666666;
        readReg1  = 5'd1;
        readReg2  = 5'd31;
        #1;
        chk("pre_reset_rd1", readData1, 32'hCAFEF00D);
        reset = 1'b1;
        #1;
        chk("mid_reset_rd1", readData1, 32'h0);
        chk("mid_reset_rd2", readData2, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        regWrite = 1'b0;
        readReg1 = 5'd6;
        readReg2 = 5'd1;
        #1;
        chk("post_reset_rd6", readData1, 32'h0);
        chk("post_reset_rd1", readData2, 32'h0);

        // first write after deassertion lands on the next edge
        regWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'h77777777;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        readReg1 = 5'd7;
        readReg2 = 5'd7;
        #1;
        chk("first_write_rd1", readData1, 32'h77777777);
        chk("first_write_rd2", readData2, 32'h77777777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
